// File: rtl/cpu_step_ctrl.sv
// Clock-enable sequencer: drives single-cycle core_en pulses for the core
// in free-run (divided rate), debounced single-step, or halt.
module cpu_step_ctrl #(
  parameter int DIV_W     = 16,
  parameter int DEB_COUNT = 62500,
  parameter int DEB_W     = 17,
  parameter int CNT_W     = 32
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             mode_run,
  input  logic             halt_req,
  input  logic             step_btn,
  input  logic [DIV_W-1:0] div_val,
  output logic             core_en,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] pulse_cnt
);
  typedef enum logic [1:0] {
    S_HALT = 2'b00,
    S_RUN  = 2'b01,
    S_STEP = 2'b10,
    S_BAD  = 2'b11
  } state_e;

  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_COUNT - 1);

  state_e           state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             en_q, en_d;
  logic [CNT_W-1:0] cnt_q;
  logic             s1_q, s2_q, deb_q, deb_prev_q;
  logic [DEB_W-1:0] deb_cnt_q;
  logic             step_ev;

  // Button path: 2-flop synchronizer, then a level accepted only after
  // DEB_COUNT consecutive cycles of disagreement with the current level.
  always_ff @(posedge clk_in) begin
    if (!rst) begin
      s1_q       <= 1'b0;
      s2_q       <= 1'b0;
      deb_q      <= 1'b0;
      deb_prev_q <= 1'b0;
      deb_cnt_q  <= '0;
    end else begin
      s1_q       <= step_btn;
      s2_q       <= s1_q;
      deb_prev_q <= deb_q;
      if (s2_q == deb_q) begin
        deb_cnt_q <= '0;
      end else if (deb_cnt_q == DEB_LAST) begin
        deb_q     <= s2_q;
        deb_cnt_q <= '0;
      end else begin
        deb_cnt_q <= deb_cnt_q + DEB_W'(1);
      end
    end
  end

  assign step_ev = deb_q & ~deb_prev_q;

  always_comb begin
    state_d = S_HALT;
    div_d   = div_q;
    en_d    = 1'b0;
    case (state_q)
      S_HALT: begin
        if (halt_req) begin
          state_d = S_HALT;
        end else if (mode_run) begin
          state_d = S_RUN;
          div_d   = '0;
        end else if (step_ev) begin
          state_d = S_STEP;
        end
      end
      S_RUN: begin
        if (halt_req || !mode_run) begin
          state_d = S_HALT;
          div_d   = '0;
        end else begin
          state_d = S_RUN;
          // >= so a lowered div_val fires immediately instead of wrapping
          if (div_q >= div_val) begin
            en_d  = 1'b1;
            div_d = '0;
          end else begin
            div_d = div_q + DIV_W'(1);
          end
        end
      end
      S_STEP: begin
        en_d    = 1'b1;
        state_d = S_HALT;
      end
      default: begin
        state_d = S_HALT;
      end
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (!rst) begin
      state_q <= S_HALT;
      div_q   <= '0;
      en_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      en_q    <= en_d;
      cnt_q   <= cnt_q + CNT_W'(en_q);
    end
  end

  assign core_en   = en_q;
  assign state     = state_q;
  assign pulse_cnt = cnt_q;
endmodule

// File: tb/tb_cpu_step_ctrl.sv
// Scoreboard bench for cpu_step_ctrl: expected pulse cycles are queued as
// stimulus is applied and matched against observed core_en pulses.
module tb_cpu_step_ctrl;
  localparam int DIV_W     = 16;
  localparam int DEB_COUNT = 4;
  localparam int DEB_W     = 17;
  localparam int CNT_W     = 8;

  logic             clk_in = 1'b0;
  logic             rst = 1'b0;
  logic             mode_run = 1'b0;
  logic             halt_req = 1'b0;
  logic             step_btn = 1'b0;
  logic [DIV_W-1:0] div_val = '0;
  logic             core_en;
  logic [1:0]       state;
  logic [CNT_W-1:0] pulse_cnt;

  int cyc = 0;
  int checks = 0;
  int failures = 0;
  int exp_q[$];
  int got_q[$];

  cpu_step_ctrl #(.DIV_W(DIV_W), .DEB_COUNT(DEB_COUNT), .DEB_W(DEB_W), .CNT_W(CNT_W)) dut (
    .clk_in(clk_in), .rst(rst), .mode_run(mode_run), .halt_req(halt_req),
    .step_btn(step_btn), .div_val(div_val), .core_en(core_en), .state(state),
    .pulse_cnt(pulse_cnt)
  );

  always #5 clk_in = ~clk_in;
  always @(posedge clk_in) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  // Advances n edges, logging the edge number of every observed pulse.
  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      if (core_en === 1'b1) got_q.push_back(cyc);
    end
  endtask

  // Reset, then enter RUN on the returned edge e.
  task automatic start_run(input logic [DIV_W-1:0] dv, output int e);
    halt_req = 1'b0; step_btn = 1'b0; rst = 1'b0;
    tick();
    rst = 1'b1; mode_run = 1'b1; div_val = dv;
    tick();
    e = cyc;
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_reset();
    mode_run = 1'b1; div_val = 16'd9; rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (core_en !== 1'b0) begin failures++; $display("FAIL reset core_en: got %b want 0", core_en); end
      checks++;
      if (state !== 2'b00) begin failures++; $display("FAIL reset state: got %b want 00", state); end
      checks++;
      if (pulse_cnt !== '0) begin failures++; $display("FAIL reset pulse_cnt: got %0d want 0", pulse_cnt); end
    end
    rst = 1'b1;
    tick();
    checks++;
    if (state !== 2'b01) begin failures++; $display("FAIL reset_exit state: got %b want 01", state); end
  endtask

  task automatic test_free_run();
    int e;
    start_run(16'd9, e);
    for (int k = 1; k <= 10; k++) exp_q.push_back(e + 10 * k);
    run_cycles(100);
    mode_run = 1'b0;
    run_cycles(1);
    checks++;
    if (pulse_cnt !== 8'd10) begin failures++; $display("FAIL free_run pulse_cnt: got %0d want 10", pulse_cnt); end
    checks++;
    if (got_q.size() != exp_q.size()) begin failures++; $display("FAIL free_run npulses: got %0d want %0d", got_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      int w, g;
      w = exp_q.pop_front(); g = got_q.pop_front();
      checks++;
      if (g !== w) begin failures++; $display("FAIL free_run pulse_edge: got %0d want %0d", g, w); end
    end
  endtask

  task automatic test_step();
    int e0;
    halt_req = 1'b0; mode_run = 1'b0; step_btn = 1'b0; div_val = '0; rst = 1'b0;
    tick();
    rst = 1'b1;
    got_q.delete(); exp_q.delete();
    e0 = cyc;
    step_btn = 1'b1;
    exp_q.push_back(e0 + DEB_COUNT + 4);
    run_cycles(DEB_COUNT + 3);
    checks++;
    if (state !== 2'b10) begin failures++; $display("FAIL step state: got %b want 10", state); end
    run_cycles(20 - (DEB_COUNT + 3));
    step_btn = 1'b0;
    run_cycles(15);
    checks++;
    if (pulse_cnt !== 8'd1) begin failures++; $display("FAIL step pulse_cnt: got %0d want 1", pulse_cnt); end
    // short bounce: s2 high for only 3 cycles
    step_btn = 1'b1;
    run_cycles(3);
    step_btn = 1'b0;
    run_cycles(20);
    checks++;
    if (got_q.size() != exp_q.size()) begin failures++; $display("FAIL step npulses: got %0d want %0d", got_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      int w, g;
      w = exp_q.pop_front(); g = got_q.pop_front();
      checks++;
      if (g !== w) begin failures++; $display("FAIL step pulse_edge: got %0d want %0d", g, w); end
    end
    checks++;
    if (pulse_cnt !== 8'd1) begin failures++; $display("FAIL bounce pulse_cnt: got %0d want 1", pulse_cnt); end
  endtask

  task automatic test_halt();
    int e;
    start_run(16'd3, e);
    exp_q.push_back(e + 4);
    run_cycles(7);
    halt_req = 1'b1;
    run_cycles(1);
    checks++;
    if (state !== 2'b00 || core_en !== 1'b0) begin
      failures++; $display("FAIL halt_prio state/en: got %b/%b want 00/0", state, core_en);
    end
    mode_run = 1'b0;
    step_btn = 1'b1;
    run_cycles(20);
    step_btn = 1'b0;
    run_cycles(12);
    halt_req = 1'b0;
    run_cycles(10);
    checks++;
    if (state !== 2'b00) begin failures++; $display("FAIL halt_step state: got %b want 00", state); end
    checks++;
    if (pulse_cnt !== 8'd1) begin failures++; $display("FAIL halt pulse_cnt: got %0d want 1", pulse_cnt); end
    checks++;
    if (got_q.size() != exp_q.size()) begin failures++; $display("FAIL halt npulses: got %0d want %0d", got_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      int w, g;
      w = exp_q.pop_front(); g = got_q.pop_front();
      checks++;
      if (g !== w) begin failures++; $display("FAIL halt pulse_edge: got %0d want %0d", g, w); end
    end
  endtask

  task automatic test_boundaries();
    int e;
    start_run(16'd0, e);
    for (int k = 1; k <= 20; k++) exp_q.push_back(e + k);
    run_cycles(20);
    checks++;
    if (got_q.size() != exp_q.size()) begin failures++; $display("FAIL div0 npulses: got %0d want %0d", got_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      int w, g;
      w = exp_q.pop_front(); g = got_q.pop_front();
      checks++;
      if (g !== w) begin failures++; $display("FAIL div0 pulse_edge: got %0d want %0d", g, w); end
    end
    // pulse_cnt wrap: after edge e+k the count is k-1
    run_cycles(236);
    checks++;
    if (pulse_cnt !== 8'd255) begin failures++; $display("FAIL wrap pre pulse_cnt: got %0d want 255", pulse_cnt); end
    run_cycles(1);
    checks++;
    if (pulse_cnt !== 8'd0) begin failures++; $display("FAIL wrap pulse_cnt: got %0d want 0", pulse_cnt); end

    start_run(16'd1000, e);
    run_cycles(500);
    div_val = 16'd2;
    for (int k = 0; k < 4; k++) exp_q.push_back(e + 501 + 3 * k);
    run_cycles(10);
    checks++;
    if (got_q.size() != exp_q.size()) begin failures++; $display("FAIL div_drop npulses: got %0d want %0d", got_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      int w, g;
      w = exp_q.pop_front(); g = got_q.pop_front();
      checks++;
      if (g !== w) begin failures++; $display("FAIL div_drop pulse_edge: got %0d want %0d", g, w); end
    end
  endtask

  task automatic test_reset_mid_run();
    int e;
    start_run(16'd3, e);
    run_cycles(2);
    rst = 1'b0;
    run_cycles(1);
    checks++;
    if (core_en !== 1'b0 || state !== 2'b00 || pulse_cnt !== '0) begin
      failures++; $display("FAIL midreset en/state/cnt: got %b/%b/%0d want 0/00/0", core_en, state, pulse_cnt);
    end
    rst = 1'b1;
    run_cycles(1);
    checks++;
    if (state !== 2'b01) begin failures++; $display("FAIL midreset reentry state: got %b want 01", state); end
    exp_q.push_back(e + 8);
    exp_q.push_back(e + 12);
    run_cycles(8);
    checks++;
    if (got_q.size() != exp_q.size()) begin failures++; $display("FAIL midreset npulses: got %0d want %0d", got_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      int w, g;
      w = exp_q.pop_front(); g = got_q.pop_front();
      checks++;
      if (g !== w) begin failures++; $display("FAIL midreset pulse_edge: got %0d want %0d", g, w); end
    end
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_step();
    test_halt();
    test_boundaries();
    test_reset_mid_run();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/cpu_step_ctrl.md
# cpu_step_ctrl

Clock-enable sequencer for the pipelined RISC-V core. Instead of deriving a slow clock, it runs entirely on `clk_in` and issues single-cycle `core_en` pulses that gate the core's pipeline registers. Three behaviours are supported:
- free-run at a programmable rate;
- single-step from a debounced push-button;
- halt.

It sits between the board inputs (button/switches) and the core's enable input.

## Interface
- `DIV_W`, 16: width of the rate divider and `div_val`.
- `DEB_COUNT`, 62500: consecutive stable cycles required to accept a button level change (0.5 ms at 125 MHz); must be ≥ 2.
- `DEB_W`, 17: debounce counter width; must hold `DEB_COUNT`.
- `CNT_W`, 32: width of the issued-pulse counter.

Ports:
- `clk_in`  in  1  system clock, 125 MHz.
- `rst`  in  1  reset; one clock; reset is synchronous and active-low.
- `mode_run`  in  1  level; 1 = free-run, 0 = step mode.
- `halt_req`  in  1  level; 1 forces HALT, highest priority.
- `step_btn`  in  1  raw asynchronous push-button, active-high.
- `div_val`  in  `DIV_W`  terminal count; RUN pulse period = `div_val`+1 cycles.
- `core_en`  out  1  registered enable pulse to the core.
- `state`  out  2  current FSM state: 00 HALT, 01 RUN, 10 STEP.
- `pulse_cnt`  out  `CNT_W`  number of `core_en` cycles issued since reset; wraps.

## Operation
**Reset** (`rst`=0 at a rising edge of `clk_in`) clears all registers: `state`=HALT, `core_en`=0, `pulse_cnt`=0, divider=0, synchronizer flops=0, debounced level=0, debounce counter=0. A reset mid-operation drops any pending pulse.

**Button path**
- `step_btn` passes through a 2-flop synchronizer (s1, s2).
- Debounce counter: increments while s2 ≠ debounced level and clears while they are equal.
- When s2 has differed for `DEB_COUNT` consecutive cycles, the debounced level takes s2 and the counter clears.
- Step event = debounced level rising (debounced & ~prev).
- Release is debounced identically; a falling edge generates no event.

**FSM** (evaluated every edge; `halt_req` checked first):
- **HALT**
  - `halt_req`=1 → stay.
  - Else `mode_run`=1 → RUN; divider cleared.
  - Else a step event → STEP.
  - `core_en`=0.
- **RUN**
  - `halt_req`=1 or `mode_run`=0 → HALT, divider cleared, no pulse issued for that cycle.
  - Else if divider ≥ `div_val`: `core_en`<=1 and divider <= 0.
  - Else divider +1 and `core_en`<=0.
  - Step events in RUN are discarded, not queued.
- **STEP**
  - `core_en`<=1 for exactly one cycle.
  - Unconditional → HALT.
  - `halt_req` asserted during STEP does not cancel the pulse.
- Encoding 11 is unreachable; if entered, next state is HALT with no pulse.

**Width and boundary rules**
- Divider compare is ≥, not ==, so lowering `div_val` below the current count produces a pulse on the next cycle and no wrap-around stall.
- `div_val` is sampled every cycle, with no shadow register.
- `div_val`=0 → `core_en` continuously high while in RUN.
- `pulse_cnt` increments on every cycle `core_en` is 1 and wraps from all-ones to 0 without a flag.

## Timing
- `core_en` and `state` are registered; no combinational input-to-output path.
- RUN steady state: one pulse every `div_val`+1 cycles.
- RUN entry: HALT→RUN at edge e; the first `core_en` high occurs in the cycle after edge e+`div_val`+1.
- Leaving RUN: if `halt_req` rises before edge h, `state`=HALT and `core_en`=0 after edge h.
- Step latency: `step_btn` held high from before edge 1 (the first sampling edge):
  - s2 high after edge 2;
  - debounced level high after edge `DEB_COUNT`+2;
  - `state`=STEP after edge `DEB_COUNT`+3;
  - `core_en` high for the single cycle after edge `DEB_COUNT`+4.
- Glitch filtering: a button pulse shorter than `DEB_COUNT` cycles at s2 produces no event.

## Test plan
Bench uses `DEB_COUNT`=4, `DIV_W`=16.

1. **Reset values:** hold `rst`=0 for 3 cycles with `mode_run`=1 → `core_en`=0, `state`=00 and `pulse_cnt`=0 throughout; RUN is entered on the first edge with `rst`=1.
2. **Free-run rate:** `mode_run`=1, `div_val`=9, run 100 cycles → exactly 10 one-cycle pulses spaced 10 apart, `pulse_cnt`=10.
3. **Single-step and debounce:**
   - Step mode, `step_btn` high for 20 cycles → exactly one `core_en` pulse, 8 cycles after the first sampling edge; `pulse_cnt`=1.
   - A 3-cycle bounce → no pulse.
4. **Halt priority:**
   - In RUN with `div_val`=3, assert `halt_req` the cycle before a due pulse → no pulse, `state`=HALT.
   - A step press while `halt_req`=1 → no pulse.
5. **Boundaries:**
   - `div_val`=0 → `core_en` high every RUN cycle.
   - Drop `div_val` from 1000 to 2 while the divider is at 500 → a pulse on the next cycle, then period 3.
6. **Reset mid-run:** with the divider at `div_val`−1, `rst`=0 for one edge → no pulse, all outputs return to reset values, and the divider restarts from 0.
